// File: rtl/turbine_frame_demux_pkg.sv
// Shared constants, FSM encoding and types for the turbine frame demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// The global turbine count is normally provided by the system-wide parameter
// header. The guard keeps that value when it is already defined, so this file
// does not override it.
`ifndef N_WindTurbine
`define N_WindTurbine 8
`endif

// FSM state encodings and the default FIFO read latency.
`define TFD_ST_IDLE     2'd0
`define TFD_ST_WAIT     2'd1
`define TFD_ST_CAPTURE  2'd2
`define TFD_ST_COMMIT   2'd3
`define TFD_READ_LAT    2

package turbine_frame_demux_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE    = `TFD_ST_IDLE,
        S_WAIT    = `TFD_ST_WAIT,
        S_CAPTURE = `TFD_ST_CAPTURE,
        S_COMMIT  = `TFD_ST_COMMIT
    } state_t;

endpackage

// File: rtl/turbine_frame_demux_if.sv
// Bundle of control, FIFO data and result signals between the demux and its users.
// Latency: n/a (wiring only).
// Backpressure: none; the FIFO burst is contiguous and the result ports are always valid.
//
// master: drives start/din/clr_err/sel and observes the results.
// slave : the demux itself.
interface turbine_frame_demux_if
    import turbine_frame_demux_pkg::*;
#(
    parameter int N_WT  = `N_WindTurbine,
    parameter int DW    = 32,
    parameter int IDX_W = $clog2(N_WT)
);
    logic                 start;
    logic [DW-1:0]        din;
    logic                 clr_err;
    logic [IDX_W-1:0]     sel;
    logic [DW-1:0]        dout_sel;
    logic [N_WT*DW-1:0]   q_bus;
    logic                 busy;
    logic                 frame_done;
    logic [CNT_W-1:0]     frame_cnt;
    logic                 overrun;

    modport master (
        output start, din, clr_err, sel,
        input  dout_sel, q_bus, busy, frame_done, frame_cnt, overrun
    );

    modport slave (
        input  start, din, clr_err, sel,
        output dout_sel, q_bus, busy, frame_done, frame_cnt, overrun
    );
endinterface

// File: rtl/turbine_frame_demux_frame_bank.sv
// Double-buffered result store: shadow bank filled word by word, active bank updated whole.
// Latency: shadow write 1 cycle; commit visible on q_bus next cycle; sel read registered, 1 cycle.
// Backpressure: none; writes and commits are accepted every cycle they are strobed.
//
// Ports: we/idx/din write shadow[idx]; commit copies shadow -> active for all words;
// q_bus exposes active flat (word k at [k*DW +: DW]); dout_sel <= active[sel], 0 when sel >= N_WT.
module turbine_frame_demux_frame_bank
    import turbine_frame_demux_pkg::*;
#(
    parameter int N_WT  = `N_WindTurbine,
    parameter int DW    = 32,
    parameter int IDX_W = $clog2(N_WT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DW-1:0]       din,
    input  logic                commit,
    input  logic [IDX_W-1:0]    sel,
    output logic [N_WT*DW-1:0]  q_bus,
    output logic [DW-1:0]       dout_sel
);

    logic [DW-1:0] shadow [N_WT];
    logic [DW-1:0] active [N_WT];
    logic [DW-1:0] rd_mux;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_WT; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
            dout_sel <= '0;
        end else begin
            for (int k = 0; k < N_WT; k++) begin
                if (we && (idx == IDX_W'(k))) begin
                    shadow[k] <= din;
                end
                // The active bank only moves as a whole, so readers never see a mixed frame.
                if (commit) begin
                    active[k] <= shadow[k];
                end
            end
            // Reads the bank before this cycle's commit lands: old frame during COMMIT.
            dout_sel <= rd_mux;
        end
    end

    // Decode rather than index so out-of-range selects fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_WT; k++) begin
            if (sel == IDX_W'(k)) begin
                rd_mux = active[k];
            end
        end
    end

    for (genvar k = 0; k < N_WT; k++) begin : g_qbus
        assign q_bus[k*DW +: DW] = active[k];
    end

endmodule

// File: rtl/turbine_frame_demux.sv
// Captures an N_WT-word FIFO burst per step and commits it atomically as a per-turbine snapshot.
// Latency: word k first visible on q_bus at t0+READ_LAT+N_WT+1 (t0 = start cycle); dout_sel +1 cycle.
// Backpressure: none; a start arriving while busy is dropped and flagged on sticky overrun.
//
// Ports: clk, rst_n (async active-low); bus (slave) carries start, din, clr_err, sel in and
// dout_sel, q_bus, busy, frame_done, frame_cnt, overrun out.
module turbine_frame_demux
    import turbine_frame_demux_pkg::*;
#(
    parameter int N_WT     = `N_WindTurbine,
    parameter int READ_LAT = `TFD_READ_LAT,
    parameter int DW       = 32,
    parameter int IDX_W    = $clog2(N_WT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    turbine_frame_demux_if.slave    bus
);

    // The start cycle itself covers one cycle of read latency, so WAIT spans READ_LAT-1
    // cycles and is skipped entirely for READ_LAT=1. The counter holds the WAIT cycles left
    // after the current one.
    localparam int LAT_W = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((READ_LAT > 1) ? READ_LAT - 2 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WT - 1);

    state_t             state_q;
    state_t             state_d;
    logic [LAT_W-1:0]   lat_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   frame_cnt_q;
    logic               overrun_q;

    logic               we;
    logic               commit;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (READ_LAT > 1) ? S_WAIT : S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (lat_q == '0) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        bus.busy       = 1'b0;
        bus.frame_done = 1'b0;
        we             = 1'b0;
        commit         = 1'b0;
        case (state_q)
            S_WAIT: begin
                bus.busy = 1'b1;
            end
            S_CAPTURE: begin
                bus.busy = 1'b1;
                we       = 1'b1;
            end
            S_COMMIT: begin
                bus.busy       = 1'b1;
                bus.frame_done = 1'b1;
                commit         = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    // Latency and word-index counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q <= '0;
            idx_q <= '0;
        end else begin
            if ((state_q == S_IDLE) && bus.start) begin
                lat_q <= LAT_LOAD;
            end else if ((state_q == S_WAIT) && (lat_q != '0)) begin
                lat_q <= lat_q - LAT_W'(1);
            end

            if (state_q == S_CAPTURE) begin
                idx_q <= idx_q + IDX_W'(1);
            end else begin
                idx_q <= '0;
            end
        end
    end

    // Frame counter and sticky overrun; a fresh overrun event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (commit) begin
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
            if (bus.start && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_err) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
    assign bus.overrun   = overrun_q;

    turbine_frame_demux_frame_bank #(
        .N_WT  (N_WT),
        .DW    (DW),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .idx      (idx_q),
        .din      (bus.din),
        .commit   (commit),
        .sel      (bus.sel),
        .q_bus    (bus.q_bus),
        .dout_sel (bus.dout_sel)
    );

endmodule

// File: tb/tb_turbine_frame_demux.sv
// Directed bench for turbine_frame_demux: N_WT=4 with READ_LAT=2 (dut) and READ_LAT=1 (dut1).
// Inputs driven and outputs sampled 1 time unit after each rising clock edge.
// Cycle c of a frame is counted from the start cycle (c=0).
module tb_turbine_frame_demux;

    localparam int N_WT  = 4;
    localparam int DW    = 32;
    localparam int IDX_W = 3;

    localparam logic [127:0] FA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [127:0] FB = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    localparam logic [127:0] FC = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    localparam logic [127:0] FD = {32'h44, 32'h33, 32'h22, 32'h11};

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    turbine_frame_demux_if #(.N_WT(N_WT), .DW(DW), .IDX_W(IDX_W)) tb_if ();
    turbine_frame_demux_if #(.N_WT(N_WT), .DW(DW), .IDX_W(IDX_W)) tb_if1 ();

    turbine_frame_demux #(.N_WT(N_WT), .READ_LAT(2), .DW(DW), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tb_if)
    );

    turbine_frame_demux #(.N_WT(N_WT), .READ_LAT(1), .DW(DW), .IDX_W(IDX_W)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tb_if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame on dut: start at c=0, optional extra start / clr_err at given cycles,
    // words at c=2..5. Returns at c=7 (first IDLE cycle after COMMIT).
    task automatic run_frame(input logic [127:0] words, input logic [127:0] old_q,
                             input int ovr_at, input int clr_at,
                             output int done_at, output logic [6:0] busy_v,
                             output int hold_err);
        done_at  = -1;
        busy_v   = '0;
        hold_err = 0;
        for (int c = 0; c < 7; c++) begin
            busy_v[c] = tb_if.busy;
            if (tb_if.frame_done && (done_at < 0)) done_at = c;
            if (tb_if.q_bus !== old_q) hold_err++;
            tb_if.start   = (c == 0) || (c == ovr_at);
            tb_if.clr_err = (c == clr_at);
            if (c >= 2 && c <= 5) tb_if.din = words[(c-2)*32 +: 32];
            else                  tb_if.din = 32'hDEAD_BEEF;
            tick();
        end
        tb_if.start   = 1'b0;
        tb_if.clr_err = 1'b0;
        tb_if.din     = '0;
    endtask

    initial begin
        int          done_at;
        int          done1;
        int          hold_err;
        logic [6:0]  busy_v;
        logic [6:0]  busy1;
        logic [31:0] exp_sel [6];

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        tb_if.start = 1'b0;  tb_if.din = '0;  tb_if.clr_err = 1'b0;  tb_if.sel = '0;
        tb_if1.start = 1'b0; tb_if1.din = '0; tb_if1.clr_err = 1'b0; tb_if1.sel = '0;

        // Reset state
        tick(); tick();
        check("rst_q_bus",      128'(tb_if.q_bus), 128'd0);
        check("rst_frame_cnt",  128'(tb_if.frame_cnt), 128'd0);
        check("rst_overrun",    128'(tb_if.overrun), 128'd0);
        check("rst_busy",       128'(tb_if.busy), 128'd0);
        check("rst_frame_done", 128'(tb_if.frame_done), 128'd0);
        check("rst_dout_sel",   128'(tb_if.dout_sel), 128'd0);
        rst_n = 1'b1;
        tick();

        // 1: single frame
        run_frame(FA, 128'd0, -1, -1, done_at, busy_v, hold_err);
        check("t1_done_at",   128'(done_at), 128'd6);
        check("t1_busy_vec",  128'(busy_v), 128'b1111110);
        check("t1_hold",      128'(hold_err), 128'd0);
        check("t1_q_bus",     tb_if.q_bus, FA);
        check("t1_frame_cnt", 128'(tb_if.frame_cnt), 128'd1);
        check("t1_busy_end",  128'(tb_if.busy), 128'd0);

        // 2: start mid-capture -> overrun; clear; then start in COMMIT with clr_err (set wins)
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        run_frame(FA, 128'd0, 3, -1, done_at, busy_v, hold_err);
        check("t2_done_at",   128'(done_at), 128'd6);
        check("t2_overrun",   128'(tb_if.overrun), 128'd1);
        check("t2_q_bus",     tb_if.q_bus, FA);
        tick(); tick(); tick();
        check("t2_no_extra",  128'(tb_if.busy), 128'd0);
        check("t2_frame_cnt", 128'(tb_if.frame_cnt), 128'd1);
        tb_if.clr_err = 1'b1; tick(); tb_if.clr_err = 1'b0;
        check("t2_clr",       128'(tb_if.overrun), 128'd0);
        run_frame(FB, FA, 6, 6, done_at, busy_v, hold_err);
        check("t2_set_wins",  128'(tb_if.overrun), 128'd1);
        check("t2_commit_st", 128'(tb_if.busy), 128'd0);
        check("t2_cnt2",      128'(tb_if.frame_cnt), 128'd2);
        check("t2_q_bus_b",   tb_if.q_bus, FB);

        // 3: back-to-back frames, 7-cycle period
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        run_frame(FA, 128'd0, -1, -1, done_at, busy_v, hold_err);
        check("t3_done_a",    128'(done_at), 128'd6);
        run_frame(FB, FA, -1, -1, done_at, busy_v, hold_err);
        check("t3_done_b",    128'(done_at), 128'd6);
        check("t3_busy_b",    128'(busy_v), 128'b1111110);
        check("t3_hold_a",    128'(hold_err), 128'd0);
        check("t3_q_bus",     tb_if.q_bus, FB);
        check("t3_frame_cnt", 128'(tb_if.frame_cnt), 128'd2);
        check("t3_overrun",   128'(tb_if.overrun), 128'd0);

        // 4: reset mid-capture clears everything immediately
        tb_if.start = 1'b1; tick();
        tb_if.start = 1'b0; tick();
        tb_if.din = 32'hC0; tick();
        tb_if.din = 32'hC1; tick();
        tb_if.din = 32'hC2;
        rst_n = 1'b0;
        #1;
        check("t4_q_bus",     tb_if.q_bus, 128'd0);
        check("t4_frame_cnt", 128'(tb_if.frame_cnt), 128'd0);
        check("t4_busy",      128'(tb_if.busy), 128'd0);
        check("t4_dout_sel",  128'(tb_if.dout_sel), 128'd0);
        tb_if.din = '0;
        tick(); rst_n = 1'b1; tick();
        run_frame(FC, 128'd0, -1, -1, done_at, busy_v, hold_err);
        check("t4_recap_done", 128'(done_at), 128'd6);
        check("t4_recap_q",    tb_if.q_bus, FC);
        check("t4_recap_cnt",  128'(tb_if.frame_cnt), 128'd1);

        // 5: sel read port; old frame during COMMIT, then sweep 0..5
        tb_if.sel = '0;
        run_frame(FD, FC, -1, -1, done_at, busy_v, hold_err);
        check("t5_sel_old",   128'(tb_if.dout_sel), 128'hC0);
        tick();
        check("t5_sel_new",   128'(tb_if.dout_sel), 128'h11);
        exp_sel = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            tb_if.sel = IDX_W'(i);
            tick();
            check($sformatf("t5_sel%0d", i), 128'(tb_if.dout_sel), 128'(exp_sel[i]));
        end
        tb_if.sel = '0;

        // 6a: frame counter wraps
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        release dut.frame_cnt_q;
        tick();
        check("t6_preload",   128'(tb_if.frame_cnt), 128'hFFFF);
        run_frame(FA, FD, -1, -1, done_at, busy_v, hold_err);
        check("t6_wrap",      128'(tb_if.frame_cnt), 128'd0);
        check("t6_wrap_q",    tb_if.q_bus, FA);

        // 6b: READ_LAT=1 build, words at c=1..4, commit at c=5
        done1 = -1;
        busy1 = '0;
        for (int c = 0; c < 7; c++) begin
            busy1[c] = tb_if1.busy;
            if (tb_if1.frame_done && (done1 < 0)) done1 = c;
            tb_if1.start = (c == 0);
            if (c >= 1 && c <= 4) tb_if1.din = FB[(c-1)*32 +: 32];
            else                  tb_if1.din = 32'hDEAD_BEEF;
            tick();
        end
        tb_if1.start = 1'b0;
        tb_if1.din   = '0;
        check("t6_rl1_done",  128'(done1), 128'd5);
        check("t6_rl1_busy",  128'(busy1), 128'b0111110);
        check("t6_rl1_q_bus", tb_if1.q_bus, FB);
        check("t6_rl1_cnt",   128'(tb_if1.frame_cnt), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
